// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch (IF)
// and load/store (DM). Data accesses are served before fetches. stall_o freezes
// the pipeline until every request of the current step has been served.
// Ports:
//   clk_i, rst_i (async, active-low), start_i (CPU run enable)
//   if_req_i/if_addr_i        -> if_rdata_o/if_ready_o    fetch side
//   dm_rd_i/dm_wr_i/dm_addr_i/dm_wdata_i -> dm_rdata_o/dm_ready_o  data side
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_rdata_i  memory macro side
//   stall_o (combinational), stall_cnt_o, conflict_cnt_o  (saturating stats)
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_rd_i,
  input  logic              dm_wr_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  localparam int unsigned LAT_W = 4;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               grant_dm_q, grant_dm_d;
  logic               grant_wr_q, grant_wr_d;
  logic               mem_en_d, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d, if_rdata_d, dm_rdata_d;
  logic               if_done_d, dm_done_d;
  logic [CNT_W-1:0]   stall_cnt_d, conflict_cnt_d;

  logic if_pend, dm_pend, first_issue, capture, other_pend, reissue, load;
  logic next_dm, next_we;

  // Request bookkeeping shared by next-state and output logic
  assign if_pend     = if_req_i & ~if_ready_o;
  assign dm_pend     = (dm_rd_i | dm_wr_i) & ~dm_ready_o;
  assign stall_o     = rst_i & start_i & (if_pend | dm_pend);
  assign first_issue = (state_q == IDLE) & start_i & (if_pend | dm_pend);
  // Capture happens MEM_LAT cycles after the ISSUE cycle
  assign capture     = (state_q == WAIT) & (lat_q == LAT_LAST);
  assign other_pend  = grant_dm_q ? if_pend : dm_pend;
  // Back-to-back issue of the second requester, no IDLE bubble
  assign reissue     = capture & start_i & other_pend;
  assign load        = first_issue | reissue;
  assign next_dm     = first_issue ? dm_pend : ~grant_dm_q;
  assign next_we     = next_dm & dm_wr_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (first_issue) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (capture) state_d = reissue ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    lat_d          = lat_q;
    grant_dm_d     = grant_dm_q;
    grant_wr_d     = grant_wr_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_o;
    mem_wdata_d    = mem_wdata_o;
    if_rdata_d     = if_rdata_o;
    dm_rdata_d     = dm_rdata_o;
    if_done_d      = if_ready_o;
    dm_done_d      = dm_ready_o;
    stall_cnt_d    = stall_cnt_o;
    conflict_cnt_d = conflict_cnt_o;

    if (load) begin
      mem_en_d    = 1'b1;
      mem_we_d    = next_we;
      mem_addr_d  = next_dm ? dm_addr_i : if_addr_i;
      mem_wdata_d = next_we ? dm_wdata_i : '0;
      grant_dm_d  = next_dm;
      grant_wr_d  = next_we;
    end

    if (state_q == ISSUE)               lat_d = LAT_W'(1);
    else if (state_q == WAIT && !capture) lat_d = lat_q + LAT_W'(1);

    // A result arriving after start_i dropped is discarded
    if (capture && start_i) begin
      if (grant_dm_q) begin
        dm_done_d = 1'b1;
        if (!grant_wr_q) dm_rdata_d = mem_rdata_i;
      end else begin
        if_done_d  = 1'b1;
        if_rdata_d = mem_rdata_i;
      end
    end

    // Step end (or CPU halted): next step starts with nothing served
    if (!start_i || !stall_o) begin
      if_done_d = 1'b0;
      dm_done_d = 1'b0;
    end

    if (stall_o && stall_cnt_o != CNT_MAX) stall_cnt_d = stall_cnt_o + CNT_W'(1);
    if (first_issue && if_pend && dm_pend && conflict_cnt_o != CNT_MAX)
      conflict_cnt_d = conflict_cnt_o + CNT_W'(1);
  end

  // Registered outputs and datapath
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lat_q          <= '0;
      grant_dm_q     <= 1'b0;
      grant_wr_q     <= 1'b0;
      mem_en_o       <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      if_rdata_o     <= '0;
      dm_rdata_o     <= '0;
      if_ready_o     <= 1'b0;
      dm_ready_o     <= 1'b0;
      stall_cnt_o    <= '0;
      conflict_cnt_o <= '0;
    end else begin
      lat_q          <= lat_d;
      grant_dm_q     <= grant_dm_d;
      grant_wr_q     <= grant_wr_d;
      mem_en_o       <= mem_en_d;
      mem_we_o       <= mem_we_d;
      mem_addr_o     <= mem_addr_d;
      mem_wdata_o    <= mem_wdata_d;
      if_rdata_o     <= if_rdata_d;
      dm_rdata_o     <= dm_rdata_d;
      if_ready_o     <= if_done_d;
      dm_ready_o     <= dm_done_d;
      stall_cnt_o    <= stall_cnt_d;
      conflict_cnt_o <= conflict_cnt_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected memory accesses and read
// results are queued by the stimulus and checked by an independent monitor.
module tb_unified_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LAT = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ready_o;
  logic          dm_rd_i, dm_wr_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_ready_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_o;
  logic [15:0]   stall_cnt_o, conflict_cnt_o;

  // Second copy with narrow counters, fed identically, to reach saturation quickly
  logic [DW-1:0] s_if_rdata, s_dm_rdata, s_mem_wdata;
  logic          s_if_ready, s_dm_ready, s_mem_en, s_mem_we, s_stall;
  logic [AW-1:0] s_mem_addr;
  logic [3:0]    s_stall_cnt, s_conflict_cnt;

  always #5 clk_i = ~clk_i;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .dm_rd_i(dm_rd_i), .dm_wr_i(dm_wr_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o),
    .stall_cnt_o(stall_cnt_o), .conflict_cnt_o(conflict_cnt_o));

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .CNT_W(4)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(s_if_rdata), .if_ready_o(s_if_ready),
    .dm_rd_i(dm_rd_i), .dm_wr_i(dm_wr_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(s_dm_rdata), .dm_ready_o(s_dm_ready),
    .mem_en_o(s_mem_en), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
    .mem_rdata_i(mem_rdata_i), .stall_o(s_stall),
    .stall_cnt_o(s_stall_cnt), .conflict_cnt_o(s_conflict_cnt));

  // Memory model: data valid exactly in cycle (mem_en cycle + 2), garbage otherwise
  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] d1;
  logic          v1;
  always @(posedge clk_i) begin
    mem_rdata_i <= v1 ? d1 : 32'hDEADBEEF;
    v1 <= mem_en_o & ~mem_we_o;
    d1 <= mem[mem_addr_o[7:2]];
    if (mem_en_o && mem_we_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", nm);
  endtask

  // Scoreboard queues
  logic [64:0]   mem_q[$];
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] dm_q[$];

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int  last_en_cyc = 0, prev_en_cyc = 0;
  logic if_prev = 1'b0, dm_prev = 1'b0;

  // Monitor: compares whatever the DUT presents against queued expectations
  always @(negedge clk_i) begin
    if (mem_en_o) begin
      prev_en_cyc = last_en_cyc;
      last_en_cyc = cyc;
      if (mem_q.size() == 0) fail_now("mem_unexpected");
      else chk("mem_access", 96'({mem_we_o, mem_addr_o, mem_wdata_o}), 96'(mem_q.pop_front()));
    end
    if (if_ready_o && !if_prev) begin
      if (if_q.size() == 0) fail_now("if_ready_unexpected");
      else chk("if_rdata", 96'(if_rdata_o), 96'(if_q.pop_front()));
    end
    if (dm_ready_o && !dm_prev) begin
      if (dm_q.size() == 0) fail_now("dm_ready_unexpected");
      else chk("dm_rdata", 96'(dm_rdata_o), 96'(dm_q.pop_front()));
    end
    if_prev = if_ready_o;
    dm_prev = dm_ready_o;
  end

  // One pipeline step: drive requests, measure stall length, release requests
  task automatic run_step(input logic ir, input logic [AW-1:0] ia, input logic rd,
                          input logic wr, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                          input int exp_stall, input string nm);
    int n;
    @(posedge clk_i); #1;
    if_req_i = ir; if_addr_i = ia;
    dm_rd_i = rd; dm_wr_i = wr; dm_addr_i = da; dm_wdata_i = wd;
    n = 0;
    @(negedge clk_i);
    while (stall_o && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    chk(nm, 96'(n), 96'(exp_stall));
    if_req_i = 1'b0; dm_rd_i = 1'b0; dm_wr_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    mem[2] = 32'hCAFEF00D;
    mem[3] = 32'h002081B3;
    rst_i = 1'b0; start_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_rd_i = 1'b0; dm_wr_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_mem_en", 96'(mem_en_o), 96'(0));
    chk("rst_ready", 96'({if_ready_o, dm_ready_o}), 96'(0));
    chk("rst_stall_cnt", 96'(stall_cnt_o), 96'(0));
    chk("rst_rdata", 96'({if_rdata_o, dm_rdata_o}), 96'(0));
    rst_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    chk("idle_stall", 96'(stall_o), 96'(0));

    // Fetch only
    mem_q.push_back({1'b0, 32'h0, 32'h0});
    if_q.push_back(32'h00500093);
    run_step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4, "fetch_stall");
    chk("fetch_rdata", 96'(if_rdata_o), 96'(32'h00500093));
    chk("fetch_stall_cnt", 96'(stall_cnt_o), 96'(4));
    chk("fetch_conflict", 96'(conflict_cnt_o), 96'(0));

    // Load + fetch: data first, fetch issued right after data capture
    mem_q.push_back({1'b0, 32'h8, 32'h0});
    mem_q.push_back({1'b0, 32'h4, 32'h0});
    dm_q.push_back(32'hCAFEF00D);
    if_q.push_back(32'h00A00113);
    run_step(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, 7, "both_stall");
    chk("both_issue_gap", 96'(last_en_cyc - prev_en_cyc), 96'(3));
    chk("both_conflict", 96'(conflict_cnt_o), 96'(1));
    chk("both_stall_cnt", 96'(stall_cnt_o), 96'(11));

    // Store 0x5 to 0x10 + fetch, then load it back
    mem_q.push_back({1'b1, 32'h10, 32'h5});
    mem_q.push_back({1'b0, 32'hC, 32'h0});
    dm_q.push_back(32'hCAFEF00D);
    if_q.push_back(32'h002081B3);
    run_step(1'b1, 32'hC, 1'b0, 1'b1, 32'h10, 32'h5, 7, "store_stall");
    mem_q.push_back({1'b0, 32'h10, 32'h0});
    dm_q.push_back(32'h5);
    run_step(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4, "load_stall");
    chk("load_back", 96'(dm_rdata_o), 96'(32'h5));

    // Read and write together act as a store; load data register unchanged
    mem_q.push_back({1'b1, 32'h14, 32'h77});
    dm_q.push_back(32'h5);
    run_step(1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'h77, 4, "rdwr_stall");
    mem_q.push_back({1'b0, 32'h14, 32'h0});
    dm_q.push_back(32'h77);
    run_step(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 4, "rdwr_load_stall");
    chk("cnt_stall_total", 96'(stall_cnt_o), 96'(30));
    chk("cnt_conflict_total", 96'(conflict_cnt_o), 96'(2));

    // Reset in the middle of WAIT
    @(posedge clk_i); #1;
    if_req_i = 1'b1; if_addr_i = 32'h0;
    mem_q.push_back({1'b0, 32'h0, 32'h0});
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midrst_mem_en", 96'(mem_en_o), 96'(0));
    chk("midrst_stall", 96'(stall_o), 96'(0));
    chk("midrst_cnts", 96'({stall_cnt_o, conflict_cnt_o}), 96'(0));
    if_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("midrst_idle", 96'({stall_o, if_ready_o, if_rdata_o}), 96'(0));

    // start_i dropped during WAIT: access finishes, result discarded
    @(posedge clk_i); #1;
    if_req_i = 1'b1; if_addr_i = 32'h4;
    mem_q.push_back({1'b0, 32'h4, 32'h0});
    repeat (3) @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk("halt_stall", 96'(stall_o), 96'(0));
    repeat (5) @(negedge clk_i);
    chk("halt_ready", 96'({if_ready_o, dm_ready_o}), 96'(0));
    chk("halt_rdata", 96'(if_rdata_o), 96'(0));
    chk("halt_stall_cnt", 96'(stall_cnt_o), 96'(2));
    if_req_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i);

    // Saturation on the narrow-counter copy: 2 + 3*4 = 14, then past 15
    for (int k = 0; k < 3; k++) begin
      mem_q.push_back({1'b0, 32'h0, 32'h0});
      if_q.push_back(32'h00500093);
      run_step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4, "sat_pre_stall");
    end
    chk("sat_pre_main", 96'(stall_cnt_o), 96'(14));
    chk("sat_pre_narrow", 96'(s_stall_cnt), 96'(14));
    mem_q.push_back({1'b0, 32'h0, 32'h0});
    if_q.push_back(32'h00500093);
    run_step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4, "sat_stall");
    chk("sat_main", 96'(stall_cnt_o), 96'(18));
    chk("sat_narrow", 96'(s_stall_cnt), 96'(15));

    repeat (3) @(negedge clk_i);
    chk("mem_q_empty", 96'(mem_q.size()), 96'(0));
    chk("rd_q_empty", 96'(if_q.size() + dm_q.size()), 96'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
